seg_display_scanner: RTL and testbench

- Time-multiplexes a DIGITS_N-digit BCD value onto one shared 7-segment decoder (4-bit NUMBER in, segment pattern out) and a one-hot anode select.
- Sits between the BCD counter chain (value source) and the display pins.
- Owns digit scheduling, anti-ghosting blanking, leading-zero suppression and tear-free value update via a LOAD/LOAD_ACK handshake.

---
 rtl/seg_display_scanner.sv | 122 ++++++++++++
 tb/tb_seg_display_scanner.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seg_display_scanner.sv
// Multiplexed 7-segment scanner: one shared BCD decoder, one-hot anodes, blanking between slots,
// leading-zero suppression and a frame-synchronous LOAD/LOAD_ACK value update.
module seg_display_scanner #(
  parameter int DIGITS_N     = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    LOAD,
  input  logic [4*DIGITS_N-1:0]   VALUE,
  input  logic                    LZ_EN,
  output logic                    LOAD_ACK,
  output logic [3:0]              NUMBER,
  output logic [DIGITS_N-1:0]     AN,
  output logic                    FRAME_DONE,
  output logic                    BAD_DIGIT
);

  localparam int SLOT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DIG_W  = (DIGITS_N > 1) ? $clog2(DIGITS_N) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(PRESCALE - 1);
  localparam logic [SLOT_W-1:0] SLOT_BLANK = SLOT_W'(BLANK_CYCLES);
  localparam logic [DIG_W-1:0]  DIG_LAST   = DIG_W'(DIGITS_N - 1);

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} slot_state_t;

  logic [SLOT_W-1:0]     r_slot;
  logic [DIG_W-1:0]      r_digit;
  logic [4*DIGITS_N-1:0] r_active;
  logic [4*DIGITS_N-1:0] r_pending;
  logic                  r_pend_vld;

  logic                  w_last_slot;
  logic                  w_commit;
  logic [SLOT_W-1:0]     w_slot_nxt;
  logic [DIG_W-1:0]      w_digit_nxt;
  logic [4*DIGITS_N-1:0] w_active_nxt;
  logic [4*DIGITS_N-1:0] w_pending_nxt;
  logic                  w_pend_vld_nxt;
  slot_state_t           w_state_nxt;
  logic [3:0]            w_nibble;
  logic                  w_bad;
  logic                  w_hide;
  logic [DIGITS_N-1:0]   w_an_nxt;
  logic [3:0]            w_num_nxt;
  logic                  w_fd_nxt;

  // Digit d is a leading zero when it and every more significant nibble are zero (never digit 0).
  function automatic logic lz_blank(input logic [4*DIGITS_N-1:0] v, input logic [DIG_W-1:0] d);
    logic upper_zero;
    logic res;
    upper_zero = 1'b1;
    res        = 1'b0;
    for (int k = DIGITS_N - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (v[4*k +: 4] == 4'd0);
      if (d == DIG_W'(k)) res = upper_zero;
    end
    return res;
  endfunction

  always_comb begin
    w_last_slot    = (r_slot == SLOT_LAST);
    w_commit       = w_last_slot && (r_digit == DIG_LAST);
    w_slot_nxt     = w_last_slot ? '0 : r_slot + 1'b1;
    w_digit_nxt    = r_digit;
    if (w_last_slot) w_digit_nxt = (r_digit == DIG_LAST) ? '0 : r_digit + 1'b1;

    w_active_nxt   = r_active;
    w_pending_nxt  = r_pending;
    w_pend_vld_nxt = r_pend_vld;
    if (w_commit) begin
      // A LOAD landing on the commit edge is newer than anything pending, so it goes straight in.
      if (LOAD)            w_active_nxt = VALUE;
      else if (r_pend_vld) w_active_nxt = r_pending;
      w_pend_vld_nxt = 1'b0;
    end else if (LOAD) begin
      w_pending_nxt  = VALUE;
      w_pend_vld_nxt = 1'b1;
    end

    // Outputs are computed from next-cycle state so the registered pins line up with the counters.
    w_state_nxt = (w_slot_nxt < SLOT_BLANK) ? ST_BLANK : ST_SHOW;
    w_nibble    = 4'd0;
    for (int k = 0; k < DIGITS_N; k++) begin
      if (w_digit_nxt == DIG_W'(k)) w_nibble = w_active_nxt[4*k +: 4];
    end
    w_bad     = (w_nibble > 4'd9);
    w_hide    = w_bad || (LZ_EN && lz_blank(w_active_nxt, w_digit_nxt));
    w_num_nxt = w_hide ? 4'd0 : w_nibble;
    w_an_nxt  = '0;
    if ((w_state_nxt == ST_SHOW) && !w_hide) w_an_nxt = DIGITS_N'(1) << w_digit_nxt;
    w_fd_nxt  = (w_slot_nxt == SLOT_LAST) && (w_digit_nxt == DIG_LAST);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_slot     <= '0;
      r_digit    <= '0;
      r_active   <= '0;
      r_pending  <= '0;
      r_pend_vld <= 1'b0;
      AN         <= '0;
      NUMBER     <= 4'd0;
      LOAD_ACK   <= 1'b0;
      FRAME_DONE <= 1'b0;
      BAD_DIGIT  <= 1'b0;
    end else begin
      r_slot     <= w_slot_nxt;
      r_digit    <= w_digit_nxt;
      r_active   <= w_active_nxt;
      r_pending  <= w_pending_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      AN         <= w_an_nxt;
      NUMBER     <= w_num_nxt;
      LOAD_ACK   <= LOAD;
      FRAME_DONE <= w_fd_nxt;
      BAD_DIGIT  <= w_bad;
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner: directed plan steps plus random frames against a cycle-count model.
module tb_seg_display_scanner;
  localparam int N = 4;
  localparam int P = 8;
  localparam int B = 2;
  localparam int F = N * P;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          LOAD = 1'b0;
  logic          LZ_EN = 1'b0;
  logic [15:0]   VALUE = 16'h0;
  logic          LOAD_ACK;
  logic [3:0]    NUMBER;
  logic [N-1:0]  AN;
  logic          FRAME_DONE;
  logic          BAD_DIGIT;

  seg_display_scanner #(.DIGITS_N(N), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .VALUE(VALUE), .LZ_EN(LZ_EN),
    .LOAD_ACK(LOAD_ACK), .NUMBER(NUMBER), .AN(AN), .FRAME_DONE(FRAME_DONE), .BAD_DIGIT(BAD_DIGIT)
  );

  always #5 CLK = ~CLK;

  int          n_vec = 0;
  int          n_err = 0;
  int          t = 0;
  logic [15:0] m_act = 16'h0;
  logic [15:0] m_pend = 16'h0;
  bit          m_flag = 1'b0;
  bit          m_ack = 1'b0;
  bit          m_lz = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  // Expected pins for cycle t: slot/digit come straight from the cycle count.
  task automatic check_outputs();
    int s, d;
    logic [3:0] nib, an_e, num_e;
    bit lzs, hide;
    s     = t % P;
    d     = (t / P) % N;
    nib   = m_act[4*d +: 4];
    lzs   = m_lz && (d > 0) && ((m_act >> (4*d)) == 16'h0);
    hide  = (nib > 4'd9) || lzs;
    an_e  = (s >= B && !hide) ? 4'(1 << d) : 4'b0;
    num_e = hide ? 4'd0 : nib;
    chk("AN", 32'(AN), 32'(an_e));
    chk("NUMBER", 32'(NUMBER), 32'(num_e));
    chk("BAD_DIGIT", 32'(BAD_DIGIT), 32'(nib > 4'd9));
    chk("FRAME_DONE", 32'(FRAME_DONE), 32'((t % F) == F - 1));
    chk("LOAD_ACK", 32'(LOAD_ACK), 32'(m_ack));
  endtask

  task automatic model_reset();
    t = 0; m_act = 16'h0; m_pend = 16'h0; m_flag = 1'b0; m_ack = 1'b0; m_lz = 1'b0;
  endtask

  task automatic step();
    bit ld, lz;
    logic [15:0] v;
    ld = LOAD; v = VALUE; lz = LZ_EN;
    @(posedge CLK); #1;
    if ((t % F) == F - 1) begin
      if (ld)          m_act = v;
      else if (m_flag) m_act = m_pend;
      m_flag = 1'b0;
    end else if (ld) begin
      m_pend = v;
      m_flag = 1'b1;
    end
    m_ack = ld;
    m_lz  = lz;
    t++;
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_to(input int phase);
    while ((t % F) != phase) step();
  endtask

  task automatic pulse(input logic [15:0] v);
    LOAD = 1'b1; VALUE = v;
    step();
    LOAD = 1'b0;
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] v;
    for (int k = 0; k < 4; k++)
      v[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    // Reset state while RST is low.
    #12;
    model_reset();
    check_outputs();
    #10 RST = 1'b1;
    check_outputs();

    // Idle first frame, LOAD 1234 at cycle 5, frame 0 keeps showing 0000.
    run(5);
    pulse(16'h1234);
    run_to(0);
    run(F);

    // Leading-zero suppression.
    LZ_EN = 1'b1;
    run_to(20); pulse(16'h0070);
    run_to(0); run(2 * F);
    run_to(20); pulse(16'h0000);
    run_to(0); run(2 * F);

    // Invalid nibble in digit 2.
    LZ_EN = 1'b0;
    run_to(20); pulse(16'h0A05);
    run_to(0); run(F);

    // Two LOADs, the second on the commit cycle; the stale 1111 must never appear.
    run_to(20); pulse(16'h1111);
    run_to(31); pulse(16'h2222);
    run(3 * F);

    // Random frames with random LOADs and LZ_EN.
    for (int f = 0; f < 30; f++) begin
      LZ_EN = 1'($urandom_range(0, 1));
      for (int c = 0; c < F; c++) begin
        LOAD  = ($urandom_range(0, 9) == 0);
        VALUE = rand_value();
        step();
      end
    end

    // LOAD held high across a commit.
    LOAD = 1'b1;
    for (int c = 0; c < 40; c++) begin
      VALUE = rand_value();
      step();
    end
    LOAD = 1'b0;
    run(F);

    // Asynchronous reset in the middle of digit 1 SHOW.
    LZ_EN = 1'b0;
    run_to(0); pulse(16'h5678);
    run_to(0);
    run_to(13);
    #2 RST = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge CLK); @(posedge CLK); #3;
    check_outputs();
    RST = 1'b1;
    run(2 * F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
